// File: rtl/awb_gain_calc_pkg.sv
// awb_pkg: shared definitions for the auto-white-balance gain calculator.
//   awb_state_t - sequencing FSM state encoding
//   calc_q_w    - quotient width (integer mean bits plus fractional gain bits)
//   unity_gain  - fixed-point value of a gain of 1.0
package awb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV   = 3'd2,
        STORE = 3'd3,
        FIN   = 3'd4
    } awb_state_t;

    function automatic int calc_q_w(input int mean_w, input int frac_w);
        return mean_w + frac_w;
    endfunction

    function automatic logic [31:0] unity_gain(input int frac_w);
        return 32'd1 << frac_w;
    endfunction

endpackage

// File: rtl/awb_gain_calc_if.sv
// awb_gain_calc_if: frame-sync, statistics and gain signals of the AWB block.
//   vsync    - frame sync, low during blanking
//   enable   - permits a new computation to start
//   ref_sel  - reference channel index
//   mean_in  - packed channel means, channel k at [k*MEAN_W +: MEAN_W]
//   gain_out - packed committed gains, same packing
//   busy     - computation in progress
//   done     - one-cycle pulse at end of computation
//   black    - committed black-scene flag
// master drives the statistics side, slave is the gain calculator.
interface awb_gain_calc_if #(
    parameter int NCH    = 3,
    parameter int MEAN_W = 16,
    parameter int GAIN_W = 16
);
    localparam int RS_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                    vsync;
    logic                    enable;
    logic [RS_W-1:0]         ref_sel;
    logic [NCH*MEAN_W-1:0]   mean_in;
    logic [NCH*GAIN_W-1:0]   gain_out;
    logic                    busy;
    logic                    done;
    logic                    black;

    modport master (
        output vsync, enable, ref_sel, mean_in,
        input  gain_out, busy, done, black
    );

    modport slave (
        input  vsync, enable, ref_sel, mean_in,
        output gain_out, busy, done, black
    );
endinterface

// File: rtl/awb_gain_calc_div_seq.sv
// awb_div_seq: sequential restoring divider, one quotient bit per cycle, MSB first.
//   clk, reset_n - clock, asynchronous active-low reset
//   start        - loads dividend and begins a division
//   dividend     - Q_W-bit dividend, captured on start
//   divisor      - MEAN_W-bit divisor, must stay stable while dividing
//   quotient     - result, valid when valid is high
//   valid        - one-cycle pulse, Q_W cycles after the start cycle ends
// A zero divisor yields an undefined quotient; the caller handles it.
module awb_div_seq
    import awb_pkg::*;
#(
    parameter int MEAN_W = 16,
    parameter int Q_W    = calc_q_w(16, 8)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [Q_W-1:0]    dividend,
    input  logic [MEAN_W-1:0] divisor,
    output logic [Q_W-1:0]    quotient,
    output logic              valid
);
    localparam int CNT_W = $clog2(Q_W + 1);

    logic [Q_W-1:0]    q_reg;
    logic [MEAN_W-1:0] rem;
    logic [CNT_W-1:0]  cnt;
    logic [MEAN_W:0]   trial;

    // Partial remainder is always below the divisor, so {rem, next bit}
    // minus divisor either borrows (top bit set) or fits in MEAN_W bits.
    assign trial    = {rem, q_reg[Q_W-1]} - {1'b0, divisor};
    assign quotient = q_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= '0;
            rem   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                q_reg <= dividend;
                rem   <= '0;
                cnt   <= CNT_W'(Q_W);
            end else if (cnt != '0) begin
                cnt   <= cnt - 1'b1;
                valid <= (cnt == CNT_W'(1));
                if (!trial[MEAN_W]) begin
                    rem   <= trial[MEAN_W-1:0];
                    q_reg <= {q_reg[Q_W-2:0], 1'b1};
                end else begin
                    rem   <= {rem[MEAN_W-2:0], q_reg[Q_W-1]};
                    q_reg <= {q_reg[Q_W-2:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: rtl/awb_gain_calc.sv
// awb_gain_calc: per-frame white-balance gain calculator.
// On a vsync falling edge (enable=1, idle) it snapshots the channel means and
// computes gain[k] = (mean[ref] << FRAC_W) / mean[k] for every channel with a
// shared sequential divider, then commits all gains atomically in blanking.
//   clk, reset_n - clock, asynchronous active-low reset
//   bus          - awb_gain_calc_if.slave (vsync, enable, ref_sel, mean_in,
//                  gain_out, busy, done, black)
//
// state | meaning
// IDLE  | waiting for start; start cycle itself is spent here
// LOAD  | launch divider for current channel
// DIV   | divider iterating, Q_W cycles
// STORE | saturate/override quotient into shadow lane
// FIN   | done pulse; results ready to commit
module awb_gain_calc
    import awb_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int MEAN_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int GAIN_W   = 16,
    parameter int GAIN_MAX = 4095,
    parameter int BLACK_TH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    awb_gain_calc_if.slave   bus
);
    localparam int Q_W   = calc_q_w(MEAN_W, FRAC_W);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(Q_W);

    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(FRAC_W));
    localparam logic [GAIN_W-1:0] GMAX_G   = GAIN_W'(GAIN_MAX);
    localparam logic [Q_W-1:0]    GMAX_Q   = Q_W'(GAIN_MAX);
    localparam logic [MEAN_W-1:0] BLACK_M  = MEAN_W'(BLACK_TH);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NCH - 1);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(Q_W - 1);

    awb_state_t             state, state_nxt;
    logic                   vsync_d;
    logic                   vsync_fall;
    logic                   start_q;
    logic [MEAN_W-1:0]      snap_mean [NCH];
    logic [CH_W-1:0]        ref_idx;
    logic [CH_W-1:0]        ref_in;
    logic [CH_W-1:0]        ch;
    logic [CNT_W-1:0]       div_cnt;
    logic [NCH*GAIN_W-1:0]  shadow_gain;
    logic                   shadow_black;
    logic                   commit_pend;
    logic                   commit_now;
    logic [NCH*GAIN_W-1:0]  gain_q;
    logic                   black_q;
    logic                   black_det;
    logic [GAIN_W-1:0]      store_val;
    logic                   div_start;
    logic [Q_W-1:0]         div_dividend;
    logic [MEAN_W-1:0]      div_divisor;
    logic [Q_W-1:0]         div_q;
    logic                   div_valid;

    assign vsync_fall   = vsync_d & ~bus.vsync;
    assign ref_in       = (int'(bus.ref_sel) >= NCH) ? '0 : bus.ref_sel;
    assign commit_now   = ((state == FIN) || commit_pend) && !bus.vsync;
    assign div_dividend = {snap_mean[ref_idx], {FRAC_W{1'b0}}};
    assign div_divisor  = snap_mean[ch];

    awb_div_seq #(
        .MEAN_W (MEAN_W),
        .Q_W    (Q_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_q),
        .valid    (div_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            IDLE:  if (start_q) state_nxt = LOAD;
            LOAD: begin
                div_start = 1'b1;
                state_nxt = DIV;
            end
            DIV:   if (div_cnt == '0) state_nxt = STORE;
            STORE: state_nxt = (ch == LAST_CH) ? FIN : LOAD;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        black_det = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (snap_mean[k] >= BLACK_M) black_det = 1'b0;
        end
    end

    // Priority: black scene, then reference override, then saturation.
    always_comb begin
        store_val = GMAX_G;
        if (black_det)
            store_val = '0;
        else if (ch == ref_idx)
            store_val = UNITY;
        else if ((div_divisor == '0) || (div_q > GMAX_Q))
            store_val = GMAX_G;
        else
            store_val = div_q[GAIN_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d      <= 1'b0;
            start_q      <= 1'b0;
            for (int k = 0; k < NCH; k++) snap_mean[k] <= '0;
            ref_idx      <= '0;
            ch           <= '0;
            div_cnt      <= '0;
            shadow_gain  <= '0;
            shadow_black <= 1'b0;
            commit_pend  <= 1'b0;
            gain_q       <= {NCH{UNITY}};
            black_q      <= 1'b0;
        end else begin
            vsync_d <= bus.vsync;
            start_q <= vsync_fall && bus.enable && (state == IDLE) && !start_q;

            if (start_q) begin
                for (int k = 0; k < NCH; k++)
                    snap_mean[k] <= bus.mean_in[k*MEAN_W +: MEAN_W];
                ref_idx     <= ref_in;
                ch          <= '0;
                commit_pend <= 1'b0;
            end else if (commit_now) begin
                commit_pend <= 1'b0;
            end else if (state == FIN) begin
                commit_pend <= 1'b1;
            end

            if (commit_now) begin
                gain_q  <= shadow_gain;
                black_q <= shadow_black;
            end

            if (state == LOAD)     div_cnt <= DIV_LAST;
            else if (state == DIV) div_cnt <= div_cnt - 1'b1;

            if ((state == STORE) && div_valid) begin
                shadow_gain[ch*GAIN_W +: GAIN_W] <= store_val;
                if (ch == LAST_CH) shadow_black <= black_det;
            end
            if ((state == STORE) && (ch != LAST_CH)) ch <= ch + 1'b1;
        end
    end

    assign bus.gain_out = gain_q;
    assign bus.black    = black_q;
    assign bus.busy     = start_q || (state != IDLE);
    assign bus.done     = (state == FIN);
endmodule
